// File: rtl/tt_um_cnt_monitor_pkg.sv
// Shared constants and types for the counter-bus rate monitor.
// Holds the uio_out bit map, the output-enable pattern and the default parameter values.
package tt_um_cnt_monitor_pkg;

  localparam int UIO_VALID   = 1;
  localparam int UIO_STALL   = 2;
  localparam int UIO_OVF     = 3;
  localparam int UIO_GLITCH  = 4;
  localparam int UIO_WIN_LSB = 5;

  localparam logic [7:0] UIO_OE_VAL = 8'b1111_1110;

  localparam int GATE_LOG2_DEF = 10;
  localparam int ACC_W_DEF     = 16;
  localparam int MAX_STEP_DEF  = 64;

  typedef struct packed {
    logic glitch;
    logic ovf;
    logic stall;
    logic valid;
  } status_t;

  function automatic logic [7:0] pack_uio(input logic [2:0] win, input status_t st);
    logic [7:0] v;
    v                      = '0;
    v[UIO_VALID]           = st.valid;
    v[UIO_STALL]           = st.stall;
    v[UIO_OVF]             = st.ovf;
    v[UIO_GLITCH]          = st.glitch;
    v[UIO_WIN_LSB +: 3]    = win;
    return v;
  endfunction

endpackage

// File: rtl/tt_cnt_sync.sv
// Brings the asynchronous count bus into the clk domain and turns each settled
// change into an unsigned 8-bit increment.
module tt_cnt_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ena_i,
  input  logic [7:0] cnt_i,
  output logic [7:0] step_o,
  output logic       step_vld_o
);

  logic [7:0] s1_q, s2_q, s3_q;
  logic [7:0] stable_q, stable_d;
  logic       primed_q, primed_d;
  logic       settled;

  // The bus is only trusted once two consecutive synchronised samples agree.
  assign settled = (s2_q == s3_q);

  always_comb begin
    stable_d = stable_q;
    primed_d = primed_q;
    if (settled) begin
      stable_d = s3_q;
      primed_d = 1'b1;
    end
    if (!ena_i) begin
      primed_d = 1'b0;
    end
  end

  // First settled sample after enable only seeds the reference value.
  assign step_o     = s3_q - stable_q;
  assign step_vld_o = ena_i & primed_q & settled;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      stable_q <= '0;
      primed_q <= 1'b0;
    end else begin
      s1_q     <= cnt_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      stable_q <= stable_d;
      primed_q <= primed_d;
    end
  end

endmodule

// File: rtl/tt_um_cnt_monitor.sv
// Rate monitor for the ring-oscillator counter tile: accumulates count increments over a
// 2**GATE_LOG2 clk gate window and publishes the total plus stall/overflow/glitch status.
module tt_um_cnt_monitor
  import tt_um_cnt_monitor_pkg::*;
#(
  parameter int GATE_LOG2 = GATE_LOG2_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_STEP  = MAX_STEP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int               SUM_W    = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [7:0]       STEP_MAX = 8'(MAX_STEP);

  logic [GATE_LOG2-1:0] timer_q, timer_d;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_upd;
  logic [ACC_W-1:0]     result_q, result_d;
  logic                 win_ovf_q, win_ovf_d;
  logic                 win_gl_q, win_gl_d;
  status_t              stat_q, stat_d;
  logic [2:0]           win_q, win_d;

  logic [7:0]           step;
  logic                 step_vld;
  logic                 accept, reject, sat_hit, win_end;
  logic [SUM_W-1:0]     sum;
  logic [15:0]          result16;
  logic                 unused_uio;

  tt_cnt_sync u_sync (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ena_i      (ena),
    .cnt_i      (ui_in),
    .step_o     (step),
    .step_vld_o (step_vld)
  );

  assign accept  = step_vld && (step != 8'd0) && (step <= STEP_MAX);
  assign reject  = step_vld && (step > STEP_MAX);
  assign sum     = {1'b0, acc_q} + SUM_W'(step);
  // A step is narrower than the accumulator, so a carry out means the total passed full scale.
  assign sat_hit = accept && sum[ACC_W];
  assign acc_upd = !accept ? acc_q : (sat_hit ? ACC_MAX : sum[ACC_W-1:0]);
  assign win_end = &timer_q;

  always_comb begin
    timer_d   = timer_q + GATE_LOG2'(1);
    acc_d     = acc_upd;
    win_ovf_d = win_ovf_q | sat_hit;
    win_gl_d  = win_gl_q | reject;
    result_d  = result_q;
    stat_d    = stat_q;
    win_d     = win_q;
    if (!ena) begin
      timer_d      = '0;
      acc_d        = '0;
      win_ovf_d    = 1'b0;
      win_gl_d     = 1'b0;
      stat_d.valid = 1'b0;
    end else if (win_end) begin
      result_d      = acc_upd;
      stat_d.stall  = (acc_upd == '0);
      stat_d.ovf    = win_ovf_d;
      stat_d.glitch = win_gl_d;
      stat_d.valid  = 1'b1;
      win_d         = win_q + 3'd1;
      acc_d         = '0;
      win_ovf_d     = 1'b0;
      win_gl_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      acc_q     <= '0;
      win_ovf_q <= 1'b0;
      win_gl_q  <= 1'b0;
      result_q  <= '0;
      stat_q    <= '0;
      win_q     <= '0;
    end else begin
      timer_q   <= timer_d;
      acc_q     <= acc_d;
      win_ovf_q <= win_ovf_d;
      win_gl_q  <= win_gl_d;
      result_q  <= result_d;
      stat_q    <= stat_d;
      win_q     <= win_d;
    end
  end

  assign result16   = 16'(result_q);
  assign uo_out     = uio_in[0] ? result16[15:8] : result16[7:0];
  assign uio_out    = pack_uio(win_q, stat_q);
  assign uio_oe     = UIO_OE_VAL;
  assign unused_uio = &{1'b0, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_cnt_monitor.sv
// Bench for tt_um_cnt_monitor: directed scenarios plus random count traffic, checked
// against a window-level model of settled bus values and their per-window increment totals.
module tb_tt_um_cnt_monitor;

  localparam int W   = 1024;
  localparam int W12 = 4096;

  logic       clk = 1'b0;
  logic       rst_n, ena, ena12;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo12, uio12, oe12;

  tt_um_cnt_monitor #(.GATE_LOG2(10), .ACC_W(16), .MAX_STEP(64)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe));

  tt_um_cnt_monitor #(.GATE_LOG2(12), .ACC_W(16), .MAX_STEP(64)) dut12 (
    .clk(clk), .rst_n(rst_n), .ena(ena12), .ui_in(ui_in), .uo_out(uo12),
    .uio_in(uio_in), .uio_out(uio12), .uio_oe(oe12));

  always #5 clk = ~clk;

  typedef struct { int edge_i; int step; } adopt_t;
  adopt_t pend[$];

  int errors = 0;
  int checks = 0;
  int kcnt, k12, macc, exp_res, exp_win, cur, mode, hold_left;
  bit mgl, movf, exp_stall, exp_ovf, exp_gl, exp_valid, known, win_done, due12, jump_armed;
  logic [15:0] r10, r12;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic epoch_clear();
    kcnt = 0; pend.delete(); macc = 0; mgl = 0; movf = 0;
  endtask

  task automatic model_reset();
    epoch_clear();
    exp_res = 0; exp_stall = 0; exp_ovf = 0; exp_gl = 0; exp_valid = 0; exp_win = 0; known = 1;
  endtask

  // Each value held for >=2 clk is adopted 3 edges after the edge that first samples it.
  task automatic drive(input int v);
    adopt_t a;
    v = v & 255;
    a.edge_i = kcnt + 3;
    a.step   = (v - cur) & 255;
    pend.push_back(a);
    cur   = v;
    ui_in = 8'(v);
  endtask

  task automatic apply(input int s);
    if (s > 0 && s <= 64) begin
      if (macc + s > 65535) begin macc = 65535; movf = 1; end
      else macc += s;
    end else if (s > 64) mgl = 1;
  endtask

  task automatic read_both();
    uio_in = {7'($urandom), 1'b0}; #1;
    r10[7:0] = uo_out; r12[7:0] = uo12;
    uio_in = {7'($urandom), 1'b1}; #1;
    r10[15:8] = uo_out; r12[15:8] = uo12;
    uio_in[0] = 1'b0;
  endtask

  task automatic check_status(input string tag);
    read_both();
    if (known) chk({tag, "_res"}, r10, 16'(exp_res));
    chk({tag, "_uio"}, {8'h00, uio_out[7:2], 2'b00}, {8'h00, exp_win[2:0], exp_gl, exp_ovf, exp_stall, 2'b00});
    chk({tag, "_valid"}, uio_out[1], exp_valid);
  endtask

  task automatic check_window();
    read_both();
    if (known) begin
      chk("win_res", r10, 16'(exp_res));
      chk("win_status", uio_out, {exp_win[2:0], exp_gl, exp_ovf, exp_stall, exp_valid, 1'b0});
    end else begin
      chk("win1_valid_num", {uio_out[7:5], uio_out[1]}, {exp_win[2:0], 1'b1});
    end
  endtask

  task automatic check12();
    read_both();
    chk("g12_res", r12, 16'hFFFF);
    chk("g12_flags", uio12[4:1], 4'b0101);
  endtask

  task automatic step_clk();
    adopt_t a;
    int e;
    win_done = 0; due12 = 0;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (!ena) begin epoch_clear(); exp_valid = 0; end
    else begin
      e = kcnt;
      while (pend.size() > 0 && pend[0].edge_i <= e) begin
        a = pend.pop_front();
        if (a.edge_i == e) apply(a.step);
      end
      if (e % W == W - 1) begin
        exp_res = macc; exp_stall = (macc == 0); exp_ovf = movf; exp_gl = mgl;
        exp_valid = 1; exp_win = (exp_win + 1) % 8;
        known = ((e + 1) / W >= 2);
        macc = 0; movf = 0; mgl = 0;
        win_done = 1;
      end
      kcnt++;
    end
    if (rst_n && ena12) begin
      if (k12 % W12 == W12 - 1 && (k12 + 1) / W12 >= 2) due12 = 1;
      k12++;
    end else k12 = 0;
    @(negedge clk);
    if (win_done) check_window();
    if (due12) check12();
  endtask

  task automatic traffic();
    int nv;
    int inc;
    if (hold_left > 0) hold_left--;
    if (hold_left == 0 && mode != 0) begin
      case (mode)
        1: begin nv = cur + 1; hold_left = 4; end
        2: begin nv = cur + 2; hold_left = 2; end
        3: begin
          inc = ($urandom_range(0, 19) == 0) ? int'($urandom_range(65, 190)) : int'($urandom_range(1, 64));
          nv = cur + inc;
          hold_left = $urandom_range(2, 5);
        end
        default: begin nv = cur + 64; hold_left = 2; end
      endcase
      if (mode == 1 && jump_armed && cur == 8'h10) begin nv = 8'h90; jump_armed = 0; end
      drive(nv);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin traffic(); step_clk(); end
  endtask

  task automatic new_epoch(input int start_v, input int m);
    mode = 0; ena = 1'b0;
    step_clk();
    drive(start_v);
    run(5);
    ena = 1'b1; mode = m; hold_left = 0;
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; ena12 = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    cur = 0; mode = 0; hold_left = 0; jump_armed = 0; k12 = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hFE);
    chk("rst_oe12", oe12, 8'hFE);
    repeat (3) step_clk();
    rst_n = 1'b1;
    run(4);

    // +1 every 4 clk: 256 counts per 1024-clk window
    ena = 1'b1; mode = 1; hold_left = 0;
    run(2 * W);
    chk("rate4_w2_res", r10, 16'h0100);
    chk("rate4_w2_flags", uio_out[4:1], 4'b0001);
    run(W);

    mode = 0; ena = 1'b0;
    step_clk();
    check_status("ena_low");

    // One count per clk on average, delivered as +2 every 2 clk so the bus settles between changes
    new_epoch(8'hF0, 2);
    run(2 * W);
    chk("wrap_w2_res", r10, 16'h0400);
    chk("wrap_hi_byte", r10[15:8], 8'h04);

    new_epoch(8'h5A, 0);
    run(2 * W);
    chk("hold_w2_res", r10, 16'h0000);
    chk("hold_w2_stall_valid", uio_out[2:1], 2'b11);

    // Single 0x10 -> 0x90 jump inside the second window
    new_epoch(8'h80, 1);
    run(W);
    jump_armed = 1;
    run(W);
    chk("jump_w2_res", r10, 16'h00FF);
    chk("jump_w2_glitch", uio_out[4], 1'b1);
    run(W);
    chk("jump_w3_res", r10, 16'h0100);
    chk("jump_w3_glitch", uio_out[4], 1'b0);

    mode = 3;
    run(3 * W);

    // +64 every 2 clk saturates the 4096-clk window of the second instance
    mode = 4; ena12 = 1'b1;
    run(2 * W12);
    ena12 = 1'b0;

    run(500);
    mode = 0; rst_n = 1'b0;
    #1;
    chk("rst_mid_uo", uo_out, 8'h00);
    chk("rst_mid_uio", uio_out, 8'h00);
    chk("rst_mid_uo12", uo12, 8'h00);
    repeat (3) step_clk();
    chk("rst_held_uio", uio_out, 8'h00);
    chk("rst_held_oe", uio_oe, 8'hFE);
    rst_n = 1'b1; mode = 1; hold_left = 0;
    run(W - 1);
    chk("rst_valid_early", uio_out[1], 1'b0);
    run(1);
    chk("rst_win_num", uio_out[7:5], 3'd1);
    run(W);
    chk("rst_w2_res", r10, 16'h0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
